uart_byte_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_byte_rx.sv | 119 +++++++++++
 tb/tb_uart_byte_rx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART receiver and frame-decoder constants and helpers.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    // Receiver state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // Command-frame bytes shared with the decoder
    localparam logic [7:0] c_FRAME_START = 8'hAA;
    localparam logic [7:0] c_FRAME_STOP  = 8'h55;
    localparam logic [7:0] c_CMD_M       = 8'd77;
    localparam logic [7:0] c_CMD_C       = 8'd67;
    localparam logic [7:0] c_CMD_D       = 8'd68;
    localparam logic [7:0] c_CMD_T       = 8'd84;

    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for an asynchronous single-bit input.
// Revision : 1.0
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_rx
// Purpose  : 8N1 UART receiver with false-start and framing-error detection.
// Revision : 1.0
// ============================================================================
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    // BAUD_DIV below 4 leaves no room for a mid-bit sample point.
    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] c_CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(BAUD_DIV - 1);

    logic             w_rx_s;
    logic             w_fall;
    logic             r_rx_d;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    // A held-low line never re-triggers: a start needs a fresh high-to-low edge.
    assign w_fall = r_rx_d & ~w_rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_d     <= 1'b1;
            r_state    <= c_ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            data       <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_rx_d     <= w_rx_s;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_fall) begin
                        r_state    <= c_ST_START;
                        r_baud_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                c_ST_START: begin
                    if (r_baud_cnt == c_CNT_HALF) begin
                        r_baud_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= c_ST_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= c_ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (r_baud_cnt == c_CNT_FULL) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {w_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    if (r_baud_cnt == c_CNT_FULL) begin
                        r_baud_cnt <= '0;
                        r_state    <= c_ST_IDLE;
                        busy       <= 1'b0;
                        if (w_rx_s) begin
                            data       <= r_shift;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_byte_rx
// Purpose  : Directed self-checking bench for uart_byte_rx at BAUD_DIV = 10.
// Revision : 1.0
// ============================================================================
module tb_uart_byte_rx;

    localparam int c_BIT_CLKS = 10;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int         n_vec;
    int         n_err;
    int         valid_cnt;
    int         ferr_cnt;
    int         overlap_cnt;
    logic       busy_seen;
    logic [7:0] rx_q[$];

    uart_byte_rx #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) begin
            valid_cnt <= valid_cnt + 1;
            rx_q.push_back(data);
        end
        if (frame_err)              ferr_cnt    <= ferr_cnt + 1;
        if (data_valid && frame_err) overlap_cnt <= overlap_cnt + 1;
        if (busy)                   busy_seen   <= 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pop_byte();
        if (rx_q.size() == 0) return 32'hDEAD_BEEF;
        return {24'h0, rx_q.pop_front()};
    endfunction

    // Frame: start, 8 data bits LSB first, stop. abort_bit >= 0 pulses rst mid that bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int abort_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                clks(5);
                rst = 1'b1;
                clks(1);
                check_eq("busy_after_rst", {31'h0, busy}, 32'h0);
                clks(1);
                rst = 1'b0;
                clks(c_BIT_CLKS - 7);
            end else begin
                clks(c_BIT_CLKS);
            end
        end
    endtask

    initial begin
        logic [7:0] frame_bytes [6];
        int v0, f0;
        frame_bytes = '{8'hAA, 8'h4D, 8'h44, 8'h05, 8'h9D, 8'h55};
        n_vec = 0; n_err = 0;
        valid_cnt = 0; ferr_cnt = 0; overlap_cnt = 0; busy_seen = 1'b0;
        rx  = 1'b1;
        rst = 1'b1;
        clks(5);
        check_eq("rst_data",  {24'h0, data},       32'h00);
        check_eq("rst_valid", {31'h0, data_valid}, 32'h0);
        check_eq("rst_ferr",  {31'h0, frame_err},  32'h0);
        check_eq("rst_busy",  {31'h0, busy},       32'h0);
        rst = 1'b0;
        clks(200);
        check_eq("idle_valid", valid_cnt, 0);
        check_eq("idle_ferr",  ferr_cnt,  0);

        // Single bytes
        send_byte(8'hAA, 1'b1, -1); clks(20);
        check_eq("aa_cnt",  valid_cnt, 1);
        check_eq("aa_q",    pop_byte(), 32'hAA);
        check_eq("aa_data", {24'h0, data}, 32'hAA);
        send_byte(8'h55, 1'b1, -1); clks(20);
        check_eq("55_cnt",  valid_cnt, 2);
        check_eq("55_q",    pop_byte(), 32'h55);
        check_eq("55_data", {24'h0, data}, 32'h55);
        send_byte(8'h00, 1'b1, -1); clks(20);
        check_eq("00_cnt",  valid_cnt, 3);
        check_eq("00_q",    pop_byte(), 32'h00);
        check_eq("00_data", {24'h0, data}, 32'h00);

        // Back-to-back decoder frame, no idle gap
        v0 = valid_cnt;
        for (int i = 0; i < 6; i++) send_byte(frame_bytes[i], 1'b1, -1);
        clks(20);
        check_eq("frm_cnt", valid_cnt - v0, 6);
        check_eq("frm_b0", pop_byte(), 32'hAA);
        check_eq("frm_b1", pop_byte(), 32'h4D);
        check_eq("frm_b2", pop_byte(), 32'h44);
        check_eq("frm_b3", pop_byte(), 32'h05);
        check_eq("frm_b4", pop_byte(), 32'h9D);
        check_eq("frm_b5", pop_byte(), 32'h55);
        check_eq("frm_ferr", ferr_cnt, 0);

        // Glitch shorter than half a bit
        v0 = valid_cnt; f0 = ferr_cnt;
        clks(2);
        busy_seen = 1'b0;
        rx = 1'b0; clks(3);
        rx = 1'b1; clks(20);
        check_eq("gl_busy_seen", {31'h0, busy_seen}, 32'h1);
        check_eq("gl_busy",      {31'h0, busy},      32'h0);
        check_eq("gl_valid",     valid_cnt - v0,     0);
        check_eq("gl_ferr",      ferr_cnt - f0,      0);
        check_eq("gl_data",      {24'h0, data},      32'h55);

        // Framing error, then a held-low break, then recovery
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'h3C, 1'b0, -1);
        rx = 1'b0; clks(50);
        check_eq("fe_ferr",  ferr_cnt - f0,  1);
        check_eq("fe_valid", valid_cnt - v0, 0);
        check_eq("fe_data",  {24'h0, data},  32'h55);
        rx = 1'b1; clks(10);
        check_eq("fe_break_busy", {31'h0, busy}, 32'h0);
        send_byte(8'h81, 1'b1, -1); clks(20);
        check_eq("fe_rec_cnt",  valid_cnt - v0, 1);
        check_eq("fe_rec_q",    pop_byte(),     32'h81);
        check_eq("fe_rec_data", {24'h0, data},  32'h81);
        check_eq("fe_rec_ferr", ferr_cnt - f0,  1);

        // Reset during data bit 4, then a clean byte
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'hF0, 1'b1, 4); clks(20);
        check_eq("ab_valid", valid_cnt - v0, 0);
        check_eq("ab_ferr",  ferr_cnt - f0,  0);
        check_eq("ab_data",  {24'h0, data},  32'h00);
        send_byte(8'h0F, 1'b1, -1); clks(20);
        check_eq("ab_rec_cnt",  valid_cnt - v0, 1);
        check_eq("ab_rec_q",    pop_byte(),     32'h0F);
        check_eq("ab_rec_data", {24'h0, data},  32'h0F);

        check_eq("no_overlap", overlap_cnt, 0);
        check_eq("q_empty",    rx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
